pending_event_dispatcher: RTL

//  Inverse of the N-to-1 OR collector: latches N independent event bits into

---
 rtl/pending_event_dispatcher.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pending_event_dispatcher.sv
// ---------------------------------------------------------------------------
// pending_event_dispatcher
//
// Latches NUM_INPUTS independent event bits into sticky pending flags and
// hands them back out one at a time over a valid/ready handshake. The
// consumer learns which inputs fired, not only that something fired.
// Service order is round-robin starting from the slot after the last one
// dispatched, so no input can be starved.
//
// Ports
//   clk           in   1            rising-edge clock
//   rst_n         in   1            synchronous reset, active-low
//   event_in      in   NUM_INPUTS   per-bit event pulses, sampled every cycle
//   evt_valid     out  1            dispatch offer valid
//   evt_ready     in   1            consumer accepts when evt_valid & evt_ready
//   evt_idx       out  IDX_W        index of the offered event
//   evt_onehot    out  NUM_INPUTS   one-hot of evt_idx, zero when !evt_valid
//   any_pending   out  1            OR of the pending flags
//   overflow      out  1            sticky: an event hit an already-set flag
//   overflow_clr  in   1            clears overflow (a new set wins)
// ---------------------------------------------------------------------------
module pending_event_dispatcher #(
    parameter int NUM_INPUTS = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_INPUTS-1:0]                         event_in,
    output logic                                          evt_valid,
    input  logic                                          evt_ready,
    output logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] evt_idx,
    output logic [NUM_INPUTS-1:0]                         evt_onehot,
    output logic                                          any_pending,
    output logic                                          overflow,
    input  logic                                          overflow_clr
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t                  state;
    logic [NUM_INPUTS-1:0]   pending;
    logic [NUM_INPUTS-1:0]   clr_mask;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        next_ptr;
    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W:0]          sum;
    logic                    sel_found;
    logic                    accept;
    logic                    ovf_set;

    assign accept      = (state == OFFER) && evt_ready;
    assign clr_mask    = accept ? evt_onehot : '0;
    assign any_pending = |pending;

    // Only a flag that survives this cycle can be "hit twice"; an event on the
    // bit being accepted right now is a fresh event, not an overflow.
    assign ovf_set = |(event_in & pending & ~clr_mask);

    // Slot after the one just served, wrapping at the last input.
    assign next_ptr = (evt_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : evt_idx + IDX_W'(1);

    // Round-robin pick: first set flag scanning ptr, ptr+1, ... modulo
    // NUM_INPUTS. The sum is one bit wider so the wrap is a single subtract.
    // NOTE: every variable written here is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_INPUTS)) begin
                sum = sum - (IDX_W + 1)'(NUM_INPUTS);
            end
            cand = sum[IDX_W-1:0];
            if (!sel_found && pending[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Pending flags and the sticky overflow bit.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | event_in;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Dispatch FSM. IDLE and OFFER alternate, so at most one dispatch every
    // two cycles; the offered flag stays set in pending until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            evt_valid  <= 1'b0;
            evt_idx    <= '0;
            evt_onehot <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        evt_idx    <= sel_idx;
                        evt_onehot <= NUM_INPUTS'(1) << sel_idx;
                        evt_valid  <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    // Offer is held untouched until the consumer takes it.
                    if (evt_ready) begin
                        evt_valid  <= 1'b0;
                        evt_onehot <= '0;
                        ptr        <= next_ptr;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
